// File: rtl/regbank_access_ctrl.sv
// Requester-side controller for the 32x32 register bank: operand issue with
// write bypass and RAW-hazard stall, plus a writeback FIFO drained into the bank.
module regbank_access_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op_rd,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        wb_hold,
  output logic [4:0]  rb_sr1,
  output logic [4:0]  rb_sr2,
  input  logic [31:0] rb_rd_data1,
  input  logic [31:0] rb_rd_data2,
  output logic        rb_write,
  output logic [4:0]  rb_dr,
  output logic [31:0] rb_wrdata
);

  localparam int AW = $clog2(WB_DEPTH);

  logic [4:0]    r_fifo_rd   [WB_DEPTH];
  logic [31:0]   r_fifo_data [WB_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_op_valid;
  logic [31:0]   r_op_a;
  logic [31:0]   r_op_b;
  logic [4:0]    r_op_rd;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hazard;
  logic          w_accept;
  logic [31:0]   w_opa;
  logic [31:0]   w_opb;

  // A queued destination conflicts with an issuing source unless it is the hardwired zero register.
  function automatic logic rd_hits(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return ((rd != 5'd0) || !ZERO_R0) && ((rd == rs1) || (rd == rs2));
  endfunction

  function automatic logic [31:0] src_sel(input logic [4:0] rs, input logic [31:0] bank_val,
                                          input logic wr, input logic [4:0] dr, input logic [31:0] wd);
    logic [31:0] v;
    if (ZERO_R0 && (rs == 5'd0)) begin
      v = 32'd0;
    end else if (wr && (dr == rs)) begin
      v = wd;
    end else begin
      v = bank_val;
    end
    return v;
  endfunction

  assign w_empty   = (r_count == {(AW+1){1'b0}});
  assign wb_ready  = reset_n && (r_count < (AW+1)'(WB_DEPTH));
  assign w_push    = wb_valid && wb_ready;
  assign w_pop     = !w_empty && !wb_hold;
  assign rb_dr     = r_fifo_rd[r_rp];
  assign rb_wrdata = r_fifo_data[r_rp];
  assign rb_write  = reset_n && w_pop && !(ZERO_R0 && (rb_dr == 5'd0));
  assign rb_sr1    = issue_rs1;
  assign rb_sr2    = issue_rs2;

  // RAW hazard: any queued entry still pending after this cycle's pop, or the entry being pushed now.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_hazard = w_hazard | (((AW+1)'(i) < r_count) && !((i == 0) && w_pop) &&
                             rd_hits(r_fifo_rd[r_rp + AW'(i)], issue_rs1, issue_rs2));
    end
    w_hazard = w_hazard | (w_push && rd_hits(wb_rd, issue_rs1, issue_rs2));
  end

  assign issue_ready = reset_n && (!r_op_valid || op_ready) && !w_hazard;
  assign w_accept    = issue_valid && issue_ready;
  assign w_opa       = src_sel(issue_rs1, rb_rd_data1, rb_write, rb_dr, rb_wrdata);
  assign w_opb       = src_sel(issue_rs2, rb_rd_data2, rb_write, rb_dr, rb_wrdata);

  // FIFO storage; contents are only meaningful below r_count, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wp]   <= wb_rd;
      r_fifo_data[r_wp] <= wb_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp    <= {AW{1'b0}};
      r_rp    <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand stage; operands freeze while stalled downstream.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op_valid <= 1'b0;
      r_op_a     <= 32'd0;
      r_op_b     <= 32'd0;
      r_op_rd    <= 5'd0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_op_a     <= w_opa;
      r_op_b     <= w_opb;
      r_op_rd    <= issue_rd;
    end else if (op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_rd    = r_op_rd;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed bench for regbank_access_ctrl with a behavioural 32x32 register bank attached.
module tb_regbank_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic [4:0]  rb_sr1, rb_sr2;
  logic [31:0] rb_rd_data1, rb_rd_data2;
  logic        rb_write;
  logic [4:0]  rb_dr;
  logic [31:0] rb_wrdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regbank_access_ctrl #(.WB_DEPTH(4), .ZERO_R0(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_hold(wb_hold),
    .rb_sr1(rb_sr1), .rb_sr2(rb_sr2), .rb_rd_data1(rb_rd_data1), .rb_rd_data2(rb_rd_data2),
    .rb_write(rb_write), .rb_dr(rb_dr), .rb_wrdata(rb_wrdata)
  );

  // Register bank: preset under reset (r5 = 0x11, others 0xA000_00nn), written by rb_write.
  logic [31:0] bank [32];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'hA000_0000 | 32'(i);
      bank[5] <= 32'h0000_0011;
    end else if (rb_write) begin
      bank[rb_dr] <= rb_wrdata;
    end
  end
  assign rb_rd_data1 = bank[rb_sr1];
  assign rb_rd_data2 = bank[rb_sr2];

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        opr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        hold;
    logic        e_ir, e_wr, e_rw, e_ov;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic opr, input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                     input logic hold);
    issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    op_ready = opr; wb_valid = wbv; wb_rd = wbrd; wb_data = wbd; wb_hold = hold;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0,      5'd0};
    tbl[1] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 32'hDEAD,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,     32'h0,      5'd1};
    tbl[2] = '{1'b1, 5'd7, 5'd5, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11,     32'h0,      5'd1};
    tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD,   32'h11,     5'd2};
    tbl[4] = '{1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD,   32'h11,     5'd2};
    tbl[5] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h5,      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD,   32'hDEAD,   5'd3};
    tbl[6] = '{1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD,   32'hDEAD,   5'd3};
    tbl[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,      32'h0,      5'd4};

    // Reset held two cycles with both requesters active.
    reset_n = 1'b0;
    drv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 32'h1234, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("reset%0d rb_write", c), 32'(rb_write), 32'd0);
      chk($sformatf("reset%0d op_valid", c), 32'(op_valid), 32'd0);
      chk($sformatf("reset%0d wb_ready", c), 32'(wb_ready), 32'd0);
      chk($sformatf("reset%0d issue_ready", c), 32'(issue_ready), 32'd0);
      chk($sformatf("reset%0d op_a", c), op_a, 32'd0);
    end
    reset_n = 1'b1;

    // Table: basic read, bypass on drain, output stall, r0 write drop.
    for (int i = 0; i < 8; i++) begin
      drv(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].opr,
          tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, tbl[i].hold);
      chk($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d wb_ready", i), 32'(wb_ready), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d rb_write", i), 32'(rb_write), 32'(tbl[i].e_rw));
      chk($sformatf("row%0d op_valid", i), 32'(op_valid), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d op_a", i), op_a, tbl[i].e_a);
      chk($sformatf("row%0d op_b", i), op_b, tbl[i].e_b);
      chk($sformatf("row%0d op_rd", i), 32'(op_rd), 32'(tbl[i].e_rd));
      tick();
    end

    // Fill the FIFO under hold: r3, r4, r3, r9.
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h31, 1'b1);
    chk("fill0 wb_ready", 32'(wb_ready), 32'd1); chk("fill0 rb_write", 32'(rb_write), 32'd0); tick();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 32'h41, 1'b1);
    chk("fill1 wb_ready", 32'(wb_ready), 32'd1); chk("fill1 rb_write", 32'(rb_write), 32'd0); tick();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h32, 1'b1);
    chk("fill2 wb_ready", 32'(wb_ready), 32'd1); tick();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 32'h91, 1'b1);
    chk("fill3 wb_ready", 32'(wb_ready), 32'd1); tick();
    drv(1'b1, 5'd1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd10, 32'hA1, 1'b1);
    chk("full wb_ready", 32'(wb_ready), 32'd0); chk("full issue_ready", 32'(issue_ready), 32'd0); tick();
    drv(1'b1, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("held issue_ready", 32'(issue_ready), 32'd0); tick();
    // Release hold: stall persists until the second r3 entry is the popping head.
    drv(1'b1, 5'd1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("drain0 issue_ready", 32'(issue_ready), 32'd0); chk("drain0 rb_write", 32'(rb_write), 32'd1);
    chk("drain0 rb_dr", 32'(rb_dr), 32'd3); chk("drain0 rb_wrdata", rb_wrdata, 32'h31); tick();
    chk("drain1 issue_ready", 32'(issue_ready), 32'd0); chk("drain1 rb_dr", 32'(rb_dr), 32'd4);
    chk("drain1 rb_wrdata", rb_wrdata, 32'h41); tick();
    chk("drain2 issue_ready", 32'(issue_ready), 32'd1); chk("drain2 rb_write", 32'(rb_write), 32'd1);
    chk("drain2 rb_dr", 32'(rb_dr), 32'd3); chk("drain2 rb_wrdata", rb_wrdata, 32'h32); tick();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("drain3 op_valid", 32'(op_valid), 32'd1); chk("drain3 op_a", op_a, 32'hA000_0001);
    chk("drain3 op_b bypass", op_b, 32'h32); chk("drain3 op_rd", 32'(op_rd), 32'd5);
    chk("drain3 rb_dr", 32'(rb_dr), 32'd9); chk("drain3 rb_write", 32'(rb_write), 32'd1); tick();
    drv(1'b1, 5'd3, 5'd9, 5'd6, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("empty rb_write", 32'(rb_write), 32'd0); chk("empty issue_ready", 32'(issue_ready), 32'd1); tick();

    // Downstream stall: operands must not refresh while writes to r3 stream through.
    for (int k = 0; k < 10; k++) begin
      drv(1'b1, 5'd3, 5'd9, 5'd7, 1'b0, 1'b1, 5'd3, 32'h7000 + 32'(k), 1'b0);
      chk($sformatf("stall%0d issue_ready", k), 32'(issue_ready), 32'd0);
      chk($sformatf("stall%0d op_valid", k), 32'(op_valid), 32'd1);
      chk($sformatf("stall%0d op_a", k), op_a, 32'h32);
      chk($sformatf("stall%0d op_b", k), op_b, 32'h91);
      chk($sformatf("stall%0d op_rd", k), 32'(op_rd), 32'd6);
      tick();
    end
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("tail rb_write", 32'(rb_write), 32'd1); chk("tail rb_wrdata", rb_wrdata, 32'h7009); tick();
    drv(1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reread issue_ready", 32'(issue_ready), 32'd1); chk("reread rb_write", 32'(rb_write), 32'd0); tick();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reread op_a", op_a, 32'h7009); chk("reread op_b", op_b, 32'h0);
    chk("reread op_rd", 32'(op_rd), 32'd8); tick();

    // Reset with a queued write and a pending operand.
    drv(1'b1, 5'd2, 5'd2, 5'd9, 1'b0, 1'b1, 5'd3, 32'hBAD, 1'b1);
    chk("pre-reset issue_ready", 32'(issue_ready), 32'd1); tick();
    reset_n = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'hBAD, 1'b0);
    chk("midreset op_valid before", 32'(op_valid), 32'd1);
    chk("midreset rb_write", 32'(rb_write), 32'd0); chk("midreset wb_ready", 32'(wb_ready), 32'd0);
    chk("midreset issue_ready", 32'(issue_ready), 32'd0); tick();
    reset_n = 1'b1;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("postreset op_valid", 32'(op_valid), 32'd0); chk("postreset op_a", op_a, 32'd0);
    chk("postreset rb_write", 32'(rb_write), 32'd0); chk("postreset wb_ready", 32'(wb_ready), 32'd1);
    chk("postreset issue_ready", 32'(issue_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
